branch_resolve_unit: RTL and testbench

- Direction predictor and resolution point for conditional branches (beq/bgt/blt) in the 16-bit pipelined CPU.
- IF stage: reads a 2-bit saturating-counter history table and emits a taken/not-taken prediction.
- ID stage: consumes the branch decision code from the decode-stage comparator, detects mispredicts, drives a one-cycle flush plus PC redirect, updates the table and keeps saturating statistics counters.

---
 rtl/cpu_branch_pkg.sv | 29 ++
 rtl/branch_history_table.sv | 52 +++++
 rtl/branch_resolve_unit.sv | 115 +++++++++++
 tb/tb_branch_resolve_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_branch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : cpu_branch_pkg                                               |
// | Purpose  : Shared branch opcodes, comparator codes, 2-bit counter        |
// |            states and the conditional-branch decode helper.             |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
package cpu_branch_pkg;

  localparam logic [3:0] OP_BEQ = 4'b0110;
  localparam logic [3:0] OP_BGT = 4'b0100;
  localparam logic [3:0] OP_BLT = 4'b0101;

  // Decode-stage comparator result codes; anything other than BR_TAKEN is not taken
  localparam logic [1:0] BR_TAKEN     = 2'b00;
  localparam logic [1:0] BR_NOT_TAKEN = 2'b01;

  // Saturating direction counter states
  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_BEQ) || (op == OP_BGT) || (op == OP_BLT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_history_table.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : branch_history_table                                         |
// | Purpose  : 2-bit saturating counter table, one async read port and one  |
// |            sync write port that carries the resolved taken bit.          |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module branch_history_table
  import cpu_branch_pkg::*;
#(
  parameter int IDX_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  output logic [1:0]          rd_cnt_o,
  input  logic                wr_en_i,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic                wr_taken_i
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0] tbl_q [ENTRIES];
  logic [1:0] w_old_cnt;
  logic [1:0] upd_d;

  // Read returns the stored value; a same-cycle write is not bypassed
  assign rd_cnt_o  = tbl_q[rd_idx_i];
  assign w_old_cnt = tbl_q[wr_idx_i];

  // Saturating step of the entry being resolved
  always_comb begin
    upd_d = w_old_cnt;
    if (wr_taken_i) begin
      if (w_old_cnt != CNT_ST) upd_d = w_old_cnt + 2'd1;
    end else begin
      if (w_old_cnt != CNT_SNT) upd_d = w_old_cnt - 2'd1;
    end
  end

  // Table storage: every entry restarts at weak-not-taken
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= CNT_WNT;
    end else if (wr_en_i) begin
      tbl_q[wr_idx_i] <= upd_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : branch_resolve_unit                                          |
// | Purpose  : IF-stage direction prediction and ID-stage resolution of      |
// |            beq/bgt/blt with flush/redirect and saturating statistics.    |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module branch_resolve_unit
  import cpu_branch_pkg::*;
#(
  parameter int IDX_BITS = 4,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       if_pc,
  input  logic [3:0]        if_opcode,
  output logic              pred_taken,
  input  logic              id_stall,
  input  logic [3:0]        id_opcode,
  input  logic [1:0]        cmp_branch,
  input  logic [15:0]       id_target,
  input  logic [15:0]       id_pc_plus2,
  output logic              flush,
  output logic              redirect_valid,
  output logic [15:0]       redirect_pc,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);

  logic [IDX_BITS-1:0] w_if_idx;
  logic [1:0]          w_if_cnt;
  logic                w_pred_raw;
  logic                w_resolve;
  logic                w_actual_taken;
  logic                w_mispredict;
  logic                w_unused;

  logic                id_live_q, id_live_d;
  logic                id_pred_q, id_pred_d;
  logic [IDX_BITS-1:0] id_idx_q,  id_idx_d;
  logic [STAT_W-1:0]   br_cnt_q,  br_cnt_d;
  logic [STAT_W-1:0]   mis_cnt_q, mis_cnt_d;

  // Halfword-aligned PCs: bit 0 and the high bits do not select an entry
  assign w_if_idx = if_pc[IDX_BITS:1];
  assign w_unused = ^{if_pc[15:IDX_BITS+1], if_pc[0]};

  branch_history_table #(
    .IDX_BITS (IDX_BITS)
  ) u_bht (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (w_if_idx),
    .rd_cnt_o   (w_if_cnt),
    .wr_en_i    (w_resolve),
    .wr_idx_i   (id_idx_q),
    .wr_taken_i (w_actual_taken)
  );

  // Prediction and resolution; rst silences every visible output
  always_comb begin
    w_pred_raw     = if_valid & is_branch(if_opcode) & w_if_cnt[1];
    w_resolve      = ~rst & id_live_q & ~id_stall & is_branch(id_opcode);
    w_actual_taken = (cmp_branch == BR_TAKEN);
    w_mispredict   = w_resolve & (w_actual_taken != id_pred_q);
    pred_taken     = w_pred_raw & ~rst;
    flush          = w_mispredict;
    redirect_valid = w_mispredict;
    redirect_pc    = 16'h0000;
    if (w_mispredict) redirect_pc = w_actual_taken ? id_target : id_pc_plus2;
    branch_count     = rst ? '0 : br_cnt_q;
    mispredict_count = rst ? '0 : mis_cnt_q;
  end

  // Next ID tracking state (flush kills the fetched instruction) and counters
  always_comb begin
    id_live_d = id_live_q;
    id_pred_d = id_pred_q;
    id_idx_d  = id_idx_q;
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (w_mispredict) begin
      id_live_d = 1'b0;
      id_pred_d = 1'b0;
      id_idx_d  = '0;
    end else if (!id_stall) begin
      id_live_d = if_valid & is_branch(if_opcode);
      id_pred_d = w_pred_raw;
      id_idx_d  = w_if_idx;
    end
    if (w_resolve && (br_cnt_q != '1))     br_cnt_d  = br_cnt_q + STAT_W'(1);
    if (w_mispredict && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + STAT_W'(1);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      id_live_q <= 1'b0;
      id_pred_q <= 1'b0;
      id_idx_q  <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      id_live_q <= id_live_d;
      id_pred_q <= id_pred_d;
      id_idx_q  <= id_idx_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// | Module   : tb_branch_resolve_unit                                       |
// | Purpose  : Self-checking bench with a behavioural predictor model and    |
// |            an expected-output scoreboard queue.                          |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int SW = 4;
  localparam logic [3:0] T_BEQ = 4'b0110;
  localparam logic [3:0] T_BGT = 4'b0100;
  localparam logic [3:0] T_BLT = 4'b0101;
  localparam logic [3:0] T_ADD = 4'b0001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_valid = 1'b0;
  logic [15:0]   if_pc = 16'h0;
  logic [3:0]    if_opcode = 4'h0;
  logic          pred_taken;
  logic          id_stall = 1'b0;
  logic [3:0]    id_opcode = 4'h0;
  logic [1:0]    cmp_branch = 2'b01;
  logic [15:0]   id_target = 16'h0;
  logic [15:0]   id_pc_plus2 = 16'h0;
  logic          flush;
  logic          redirect_valid;
  logic [15:0]   redirect_pc;
  logic [SW-1:0] branch_count;
  logic [SW-1:0] mispredict_count;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .IDX_BITS (4),
    .STAT_W   (SW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .if_opcode        (if_opcode),
    .pred_taken       (pred_taken),
    .id_stall         (id_stall),
    .id_opcode        (id_opcode),
    .cmp_branch       (cmp_branch),
    .id_target        (id_target),
    .id_pc_plus2      (id_pc_plus2),
    .flush            (flush),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  typedef struct packed {
    logic          pt;
    logic          fl;
    logic          rv;
    logic [15:0]   rpc;
    logic [SW-1:0] bc;
    logic [SW-1:0] mc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  logic [1:0]    m_tbl [16];
  logic          m_live = 1'b0;
  logic          m_pred = 1'b0;
  logic [3:0]    m_idx  = 4'h0;
  logic [SW-1:0] m_bc   = '0;
  logic [SW-1:0] m_mc   = '0;
  logic          m_init = 1'b0;

  function automatic logic m_isbr(input logic [3:0] op);
    return (op == 4'b0110) || (op == 4'b0100) || (op == 4'b0101);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // One clock cycle: drive, predict, compare at negedge+1, advance the model
  task automatic cyc(input logic v, input logic [15:0] pc, input logic [3:0] op,
                     input logic st, input logic [3:0] idop, input logic [1:0] cmp,
                     input logic [15:0] tgt, input logic [15:0] pp2, input logic r);
    exp_t e;
    logic pt, res, act, mis;
    @(negedge clk);
    rst = r; if_valid = v; if_pc = pc; if_opcode = op; id_stall = st;
    id_opcode = idop; cmp_branch = cmp; id_target = tgt; id_pc_plus2 = pp2;
    pt  = !r && v && m_isbr(op) && m_tbl[pc[4:1]][1];
    res = !r && m_live && !st && m_isbr(idop);
    act = (cmp == 2'b00);
    mis = res && (act != m_pred);
    e.pt  = pt;
    e.fl  = mis;
    e.rv  = mis;
    e.rpc = mis ? (act ? tgt : pp2) : 16'h0000;
    e.bc  = r ? '0 : m_bc;
    e.mc  = r ? '0 : m_mc;
    sb_q.push_back(e);
    #1;
    e = sb_q.pop_front();
    chk("pred_taken", pred_taken, e.pt);
    chk("flush", flush, e.fl);
    chk("redirect_valid", redirect_valid, e.rv);
    chk("redirect_pc", redirect_pc, e.rpc);
    chk("branch_count", branch_count, e.bc);
    chk("mispredict_count", mispredict_count, e.mc);
    if (m_init)
      for (int i = 0; i < 16; i++) chk($sformatf("tbl%0d", i), dut.u_bht.tbl_q[i], m_tbl[i]);
    if (r) begin
      for (int i = 0; i < 16; i++) m_tbl[i] = 2'b01;
      m_live = 1'b0; m_pred = 1'b0; m_idx = 4'h0;
      m_bc = '0; m_mc = '0; m_init = 1'b1;
    end else begin
      if (res) begin
        if (act) begin
          if (m_tbl[m_idx] != 2'b11) m_tbl[m_idx] = m_tbl[m_idx] + 2'd1;
        end else begin
          if (m_tbl[m_idx] != 2'b00) m_tbl[m_idx] = m_tbl[m_idx] - 2'd1;
        end
        if (m_bc != '1) m_bc = m_bc + 1'b1;
        if (mis && (m_mc != '1)) m_mc = m_mc + 1'b1;
      end
      if (mis) begin
        m_live = 1'b0; m_pred = 1'b0; m_idx = 4'h0;
      end else if (!st) begin
        m_live = v && m_isbr(op);
        m_pred = pt;
        m_idx  = pc[4:1];
      end
    end
  endtask

  task automatic idle(input logic r);
    cyc(1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 2'b01, 16'h0, 16'h0, r);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_tbl[i] = 2'b01;
    idle(1'b1);
    idle(1'b1);

    // Cold beq predicted not taken, resolves taken
    cyc(1'b1, 16'h0010, T_BEQ, 1'b0, 4'h0, 2'b01, 16'h0, 16'h0, 1'b0);
    chk("t1_pred", pred_taken, 1'b0);
    cyc(1'b0, 16'h0, 4'h0, 1'b0, T_BEQ, 2'b00, 16'h0040, 16'h0012, 1'b0);
    chk("t1_flush", flush, 1'b1);
    chk("t1_rpc", redirect_pc, 16'h0040);
    // Refetch now predicted taken, resolves not taken
    cyc(1'b1, 16'h0010, T_BEQ, 1'b0, 4'h0, 2'b01, 16'h0, 16'h0, 1'b0);
    chk("t1_mcnt", mispredict_count, 1);
    chk("t1_e8", dut.u_bht.tbl_q[8], 2'b10);
    chk("t2_pred", pred_taken, 1'b1);
    cyc(1'b0, 16'h0, 4'h0, 1'b0, T_BEQ, 2'b01, 16'h0040, 16'h0012, 1'b0);
    chk("t2_flush", flush, 1'b1);
    chk("t2_rpc", redirect_pc, 16'h0012);

    // Five taken resolutions of blt at 0x0004
    cyc(1'b1, 16'h0004, T_BLT, 1'b0, 4'h0, 2'b01, 16'h0, 16'h0, 1'b0);
    chk("t2_e8", dut.u_bht.tbl_q[8], 2'b01);
    cyc(1'b1, 16'h0004, T_BLT, 1'b0, T_BLT, 2'b00, 16'h0080, 16'h0006, 1'b0);
    cyc(1'b1, 16'h0004, T_BLT, 1'b0, 4'h0, 2'b01, 16'h0, 16'h0, 1'b0);
    repeat (3) cyc(1'b1, 16'h0004, T_BLT, 1'b0, T_BLT, 2'b00, 16'h0080, 16'h0006, 1'b0);
    cyc(1'b0, 16'h0, 4'h0, 1'b0, T_BLT, 2'b00, 16'h0080, 16'h0006, 1'b0);
    chk("t3_flush5", flush, 1'b0);
    chk("t3_e2_sat", dut.u_bht.tbl_q[2], 2'b11);
    idle(1'b0);
    chk("t3_bcnt", branch_count, 7);
    chk("t3_mcnt", mispredict_count, 3);

    // Stall holds a mispredicting branch for three cycles
    cyc(1'b1, 16'h0020, T_BEQ, 1'b0, 4'h0, 2'b01, 16'h0, 16'h0, 1'b0);
    repeat (3) begin
      cyc(1'b0, 16'h0, 4'h0, 1'b1, T_BEQ, 2'b00, 16'h0100, 16'h0022, 1'b0);
      chk("t4_stall_flush", flush, 1'b0);
    end
    cyc(1'b0, 16'h0, 4'h0, 1'b0, T_BEQ, 2'b00, 16'h0100, 16'h0022, 1'b0);
    chk("t4_flush", flush, 1'b1);
    chk("t4_rpc", redirect_pc, 16'h0100);
    cyc(1'b0, 16'h0, 4'h0, 1'b0, T_BEQ, 2'b00, 16'h0100, 16'h0022, 1'b0);
    chk("t4_once", flush, 1'b0);
    chk("t4_bcnt", branch_count, 8);

    // Non-branch in ID is ignored, even behind a live branch
    cyc(1'b1, 16'h0030, T_ADD, 1'b0, 4'h0, 2'b01, 16'h0, 16'h0, 1'b0);
    cyc(1'b0, 16'h0, 4'h0, 1'b0, T_ADD, 2'b00, 16'h0200, 16'h0032, 1'b0);
    chk("t5_nb_flush", flush, 1'b0);
    cyc(1'b1, 16'h0030, T_BEQ, 1'b0, 4'h0, 2'b01, 16'h0, 16'h0, 1'b0);
    cyc(1'b0, 16'h0, 4'h0, 1'b0, T_ADD, 2'b00, 16'h0200, 16'h0032, 1'b0);
    chk("t5_nb2_flush", flush, 1'b0);
    // Mispredict followed by a stall still clears tracking
    cyc(1'b1, 16'h0030, T_BEQ, 1'b0, 4'h0, 2'b01, 16'h0, 16'h0, 1'b0);
    cyc(1'b1, 16'h0030, T_BEQ, 1'b0, T_BEQ, 2'b00, 16'h0200, 16'h0032, 1'b0);
    chk("t5_flush", flush, 1'b1);
    cyc(1'b0, 16'h0, 4'h0, 1'b1, T_BEQ, 2'b00, 16'h0200, 16'h0032, 1'b0);
    cyc(1'b0, 16'h0, 4'h0, 1'b0, T_BEQ, 2'b00, 16'h0200, 16'h0032, 1'b0);
    chk("t5_cleared", flush, 1'b0);
    chk("t5_bcnt", branch_count, 9);
    chk("t5_mcnt", mispredict_count, 5);

    // Reset while a mispredicting bgt sits in ID
    cyc(1'b1, 16'h000C, T_BGT, 1'b0, 4'h0, 2'b01, 16'h0, 16'h0, 1'b0);
    cyc(1'b0, 16'h0, 4'h0, 1'b0, T_BGT, 2'b00, 16'h0300, 16'h000E, 1'b1);
    chk("t6_flush", flush, 1'b0);
    chk("t6_rv", redirect_valid, 1'b0);
    idle(1'b0);
    chk("t6_bcnt", branch_count, 0);
    chk("t6_mcnt", mispredict_count, 0);
    for (int i = 0; i < 16; i++) chk($sformatf("t6_e%0d", i), dut.u_bht.tbl_q[i], 2'b01);

    // Statistics saturate at all-ones
    repeat (40) cyc(1'b1, 16'h0002, T_BEQ, 1'b0, T_BEQ, 2'($urandom_range(0, 1)),
                    16'h0400, 16'h0004, 1'b0);
    idle(1'b0);
    chk("t7_bsat", branch_count, 4'hF);

    // Random traffic with occasional resets
    repeat (300) begin
      logic [3:0] op, idop;
      case ($urandom_range(0, 4))
        0: op = T_BEQ;
        1: op = T_BGT;
        2: op = T_BLT;
        3: op = T_ADD;
        default: op = 4'($urandom);
      endcase
      idop = ($urandom_range(0, 5) == 0) ? T_ADD : T_BLT;
      cyc(1'($urandom), 16'($urandom_range(0, 63)), op, ($urandom_range(0, 3) == 0),
          idop, 2'($urandom), 16'($urandom), 16'($urandom), ($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
